// File: rtl/input_bus_pkg.sv
// Shared packet layout and sizing for the RANC grid edge blocks (router, input bus, output bus).
// Packet layout is {dx, dy, axon, tick}, with tick in the LSBs.
package input_bus_pkg;

  localparam int PACKET_WIDTH = 30;
  localparam int DX_MSB       = 29;
  localparam int DX_LSB       = 21;
  localparam int DY_MSB       = 20;
  localparam int DY_LSB       = 12;
  localparam int DX_W         = DX_MSB - DX_LSB + 1;
  localparam int DY_W         = DY_MSB - DY_LSB + 1;
  localparam int NUM_AXONS    = 256;
  localparam int NUM_TICKS    = 16;
  localparam int AXON_W       = $clog2(NUM_AXONS);
  localparam int TICK_W       = $clog2(NUM_TICKS);
  localparam int FIFO_DEPTH   = 8;
  localparam int PTR_W        = $clog2(FIFO_DEPTH) + 1;
  localparam int COUNT_W      = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // True when the packet width matches the sum of its fields.
  function automatic bit packet_width_ok(input int pw, input int dxw, input int dyw,
                                         input int axw, input int tkw);
    return pw == (dxw + dyw + axw + tkw);
  endfunction

endpackage

// File: rtl/input_bus_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is always visible on dout.
// Pointers carry one extra wrap bit, so full and empty can be told apart.
module input_bus_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wen,
  input  logic [WIDTH-1:0]           din,
  input  logic                       ren,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign do_wr = wen && !full;
  assign do_rd = ren && !empty;
  assign dout  = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage is not reset; stale contents are never visible because the pointers are.
  always_ff @(posedge clk) begin
    if (do_wr) mem_reg[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/input_bus.sv
// Host-to-grid injection port: buffers host spike packets and feeds the west input of a router.
// Build option INPUT_BUS_PKT_COUNT_EN adds a saturating pkt_count of packets taken by the router.
module input_bus
  import input_bus_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PACKET_WIDTH-1:0] host_packet,
  input  logic                    host_valid,
  output logic                    host_ready,
  output logic [PACKET_WIDTH-1:0] east_out,
  output logic                    empty_out_east,
  input  logic                    ren_in_east,
  input  logic                    drain_req,
  output logic                    drain_done,
  output logic                    err_dx_zero
`ifdef INPUT_BUS_PKT_COUNT_EN
  ,
  output logic [COUNT_W-1:0]      pkt_count
`endif
);

  if (!packet_width_ok(PACKET_WIDTH, DX_W, DY_W, AXON_W, TICK_W)) begin : g_width_check
    $error("input_bus: PACKET_WIDTH does not match the packet field widths");
  end

  state_t                  state_reg;
  state_t                  state_next;
  logic                    err_dx_zero_reg;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [PTR_W-1:0]        fifo_count;
  logic [PACKET_WIDTH-1:0] fifo_dout;
  logic                    accept;
  logic                    dx_bad;
  logic                    pop;

  // Routing only moves packets eastward from here, so dx must be strictly positive.
  assign dx_bad     = host_packet[DX_MSB] || (host_packet[DX_MSB:DX_LSB] == '0);
  assign host_ready = !rst && !fifo_full && (state_reg == IDLE);
  assign accept     = host_valid && host_ready;
  assign pop        = ren_in_east && !fifo_empty;

  assign empty_out_east = fifo_empty;
  assign east_out       = fifo_empty ? '0 : fifo_dout;
  assign err_dx_zero    = err_dx_zero_reg;

  input_bus_fifo #(
    .WIDTH (PACKET_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wen   (accept && !dx_bad),
    .din   (host_packet),
    .ren   (ren_in_east),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      err_dx_zero_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      err_dx_zero_reg <= accept && dx_bad;
    end
  end

  always_comb begin
    state_next = state_reg;
    drain_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (drain_req) state_next = DRAIN;
      end
      DRAIN: begin
        drain_done = (fifo_count == '0);
        if (drain_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef INPUT_BUS_PKT_COUNT_EN
  logic [COUNT_W-1:0] pkt_count_reg;

  always_ff @(posedge clk) begin
    if (rst || drain_done) begin
      pkt_count_reg <= '0;
    end else if (pop && (pkt_count_reg != '1)) begin
      pkt_count_reg <= pkt_count_reg + COUNT_W'(1);
    end
  end

  assign pkt_count = pkt_count_reg;
`else
  logic unused_pop;
  assign unused_pop = pop;
`endif

endmodule

// File: tb/tb_input_bus.sv
// Directed testbench for input_bus; each task drives one scenario and checks inline.
// Honours INPUT_BUS_PKT_COUNT_EN to connect and check pkt_count.
module tb_input_bus;
  import input_bus_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [PACKET_WIDTH-1:0] host_packet;
  logic                    host_valid;
  logic                    host_ready;
  logic [PACKET_WIDTH-1:0] east_out;
  logic                    empty_out_east;
  logic                    ren_in_east;
  logic                    drain_req;
  logic                    drain_done;
  logic                    err_dx_zero;
`ifdef INPUT_BUS_PKT_COUNT_EN
  logic [15:0]             pkt_count;
`endif

  int total = 0;
  int bad = 0;
  int exp_pops = 0;

  always #5 clk = ~clk;

  input_bus dut (
    .clk            (clk),
    .rst            (rst),
    .host_packet    (host_packet),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .east_out       (east_out),
    .empty_out_east (empty_out_east),
    .ren_in_east    (ren_in_east),
    .drain_req      (drain_req),
    .drain_done     (drain_done),
    .err_dx_zero    (err_dx_zero)
`ifdef INPUT_BUS_PKT_COUNT_EN
    ,
    .pkt_count      (pkt_count)
`endif
  );

  function automatic logic [PACKET_WIDTH-1:0] mk_pkt(input int dx, input int dy,
                                                     input int axon, input int tick);
    return {9'(dx), 9'(dy), 8'(axon), 4'(tick)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; host_packet = '0; host_valid = 1'b0; ren_in_east = 1'b0; drain_req = 1'b0;
    tick(); tick();
    total++; if (empty_out_east !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty_out_east); end
    total++; if (east_out !== '0) begin bad++; $display("FAIL reset_east_out got=%h want=0", east_out); end
    total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", host_ready); end
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL reset_drain_done got=%b want=0", drain_done); end
    total++; if (err_dx_zero !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_dx_zero); end
`ifdef INPUT_BUS_PKT_COUNT_EN
    total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL reset_pkt_count got=%0d want=0", pkt_count); end
`endif
    rst = 1'b0;
    #1;
    total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", host_ready); end
    exp_pops = 0;
    $display("reset: empty=%b ready=%b", empty_out_east, host_ready);
  endtask

  task automatic test_single();
    host_packet = mk_pkt(1, 0, 5, 3); host_valid = 1'b1;
    tick();
    host_valid = 1'b0;
    total++; if (east_out !== 30'h00200053) begin bad++; $display("FAIL single_east_out got=%h want=00200053", east_out); end
    total++; if (empty_out_east !== 1'b0) begin bad++; $display("FAIL single_empty got=%b want=0", empty_out_east); end
    tick();
    total++; if (east_out !== 30'h00200053) begin bad++; $display("FAIL single_hold got=%h want=00200053", east_out); end
    ren_in_east = 1'b1;
    tick();
    ren_in_east = 1'b0; exp_pops++;
    total++; if (empty_out_east !== 1'b1 || east_out !== '0) begin
      bad++; $display("FAIL single_pop got empty=%b out=%h want empty=1 out=0", empty_out_east, east_out);
    end
    $display("single: pushed and popped 00200053");
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      host_packet = mk_pkt(2, 1, i, 0); host_valid = 1'b1;
      tick();
    end
    total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_full got=%b want=0", host_ready); end
    host_packet = mk_pkt(2, 1, 8, 0);
    tick(); tick();
    total++; if (east_out !== mk_pkt(2, 1, 0, 0)) begin bad++; $display("FAIL fill_head got=%h want=%h", east_out, mk_pkt(2, 1, 0, 0)); end
    ren_in_east = 1'b1;
    tick();
    ren_in_east = 1'b0; exp_pops++;
    total++; if (east_out !== mk_pkt(2, 1, 1, 0)) begin bad++; $display("FAIL fill_pop_head got=%h want=%h", east_out, mk_pkt(2, 1, 1, 0)); end
    total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_after_pop got=%b want=1", host_ready); end
    tick();
    host_valid = 1'b0;
    total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL fill_ninth_accepted got=%b want=0", host_ready); end
    $display("fill: 8 queued, ninth accepted after one pop");
  endtask

  task automatic test_push_pop();
    ren_in_east = 1'b1;
    tick();
    exp_pops++;
    total++; if (east_out !== mk_pkt(2, 1, 2, 0)) begin bad++; $display("FAIL pp_first_pop got=%h want=%h", east_out, mk_pkt(2, 1, 2, 0)); end
    for (int k = 0; k < 3; k++) begin
      host_packet = mk_pkt(2, 1, 9 + k, 0); host_valid = 1'b1; ren_in_east = 1'b1;
      tick();
      exp_pops++;
      total++; if (east_out !== mk_pkt(2, 1, 3 + k, 0) || host_ready !== 1'b1) begin
        bad++; $display("FAIL pp_both k=%0d got=%h ready=%b want=%h ready=1", k, east_out, host_ready, mk_pkt(2, 1, 3 + k, 0));
      end
    end
    host_valid = 1'b0; ren_in_east = 1'b0;
    for (int k = 0; k < 7; k++) begin
      total++; if (east_out !== mk_pkt(2, 1, 5 + k, 0)) begin
        bad++; $display("FAIL pp_order k=%0d got=%h want=%h", k, east_out, mk_pkt(2, 1, 5 + k, 0));
      end
      ren_in_east = 1'b1;
      tick();
      exp_pops++;
    end
    ren_in_east = 1'b0;
    total++; if (empty_out_east !== 1'b1) begin bad++; $display("FAIL pp_final_empty got=%b want=1", empty_out_east); end
    $display("push_pop: occupancy held at 7, order 5..11 drained");
  endtask

  task automatic test_dx_zero();
    host_packet = mk_pkt(0, 3, 1, 1); host_valid = 1'b1;
    total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL dx0_ready got=%b want=1", host_ready); end
    tick();
    total++; if (err_dx_zero !== 1'b1 || empty_out_east !== 1'b1) begin
      bad++; $display("FAIL dx0_drop got err=%b empty=%b want err=1 empty=1", err_dx_zero, empty_out_east);
    end
    host_packet = mk_pkt(-1, 0, 2, 2);
    tick();
    host_valid = 1'b0;
    total++; if (err_dx_zero !== 1'b1 || empty_out_east !== 1'b1) begin
      bad++; $display("FAIL dxneg_drop got err=%b empty=%b want err=1 empty=1", err_dx_zero, empty_out_east);
    end
    tick();
    total++; if (err_dx_zero !== 1'b0) begin bad++; $display("FAIL dx_err_clear got=%b want=0", err_dx_zero); end
    $display("dx_zero: dx=0 and dx=-1 dropped with error pulses");
  endtask

  task automatic test_drain();
    for (int i = 0; i < 3; i++) begin
      host_packet = mk_pkt(1, 0, 20 + i, 0); host_valid = 1'b1;
      tick();
    end
    host_valid = 1'b0; drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    total++; if (host_ready !== 1'b0 || drain_done !== 1'b0) begin
      bad++; $display("FAIL drain_enter got ready=%b done=%b want ready=0 done=0", host_ready, drain_done);
    end
    host_packet = mk_pkt(1, 0, 99, 0); host_valid = 1'b1; ren_in_east = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_pops++;
      total++; if (drain_done !== 1'b0 || east_out !== mk_pkt(1, 0, 21 + i, 0)) begin
        bad++; $display("FAIL drain_pop i=%0d got done=%b out=%h want done=0 out=%h", i, drain_done, east_out, mk_pkt(1, 0, 21 + i, 0));
      end
    end
    tick();
    exp_pops++; ren_in_east = 1'b0;
    total++; if (drain_done !== 1'b1 || empty_out_east !== 1'b1) begin
      bad++; $display("FAIL drain_done got done=%b empty=%b want done=1 empty=1", drain_done, empty_out_east);
    end
`ifdef INPUT_BUS_PKT_COUNT_EN
    total++; if (pkt_count !== 16'(exp_pops)) begin bad++; $display("FAIL drain_pkt_count got=%0d want=%0d", pkt_count, exp_pops); end
`endif
    tick();
    host_valid = 1'b0;
    total++; if (drain_done !== 1'b0 || host_ready !== 1'b1 || empty_out_east !== 1'b1) begin
      bad++; $display("FAIL drain_exit got done=%b ready=%b empty=%b want 0 1 1", drain_done, host_ready, empty_out_east);
    end
`ifdef INPUT_BUS_PKT_COUNT_EN
    total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL drain_count_clear got=%0d want=0", pkt_count); end
`endif
    exp_pops = 0;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    total++; if (drain_done !== 1'b1) begin bad++; $display("FAIL drain_empty_done got=%b want=1", drain_done); end
    tick();
    total++; if (drain_done !== 1'b0 || host_ready !== 1'b1) begin
      bad++; $display("FAIL drain_empty_exit got done=%b ready=%b want 0 1", drain_done, host_ready);
    end
    $display("drain: 3 popped then done, empty drain done next cycle");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      host_packet = mk_pkt(3, 2, 40 + i, 1); host_valid = 1'b1;
      tick();
    end
    host_valid = 1'b0; ren_in_east = 1'b1;
    tick();
    ren_in_east = 1'b0; exp_pops++;
    total++; if (east_out !== mk_pkt(3, 2, 41, 1)) begin bad++; $display("FAIL rmid_head got=%h want=%h", east_out, mk_pkt(3, 2, 41, 1)); end
`ifdef INPUT_BUS_PKT_COUNT_EN
    total++; if (pkt_count !== 16'(exp_pops)) begin bad++; $display("FAIL rmid_count_pre got=%0d want=%0d", pkt_count, exp_pops); end
`endif
    rst = 1'b1;
    tick();
    total++; if (empty_out_east !== 1'b1 || east_out !== '0 || drain_done !== 1'b0) begin
      bad++; $display("FAIL rmid_flush got empty=%b out=%h done=%b want 1 0 0", empty_out_east, east_out, drain_done);
    end
`ifdef INPUT_BUS_PKT_COUNT_EN
    total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", pkt_count); end
`endif
    rst = 1'b0;
    tick();
    total++; if (empty_out_east !== 1'b1 || host_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_after got empty=%b ready=%b want 1 1", empty_out_east, host_ready);
    end
    $display("reset_mid: 4 queued packets discarded");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_push_pop();
    test_dx_zero();
    test_drain();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
